// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: FSM states, error codes, FIFO entry layout
// and the select-index helper.
package apb_mon_pkg;

   localparam int MON_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef enum logic [3:0] {
      ERR_NONE         = 4'd0,
      ERR_MULTI_SEL    = 4'd1,
      ERR_EN_NO_SETUP  = 4'd2,
      ERR_EN_IN_SETUP  = 4'd3,
      ERR_UNSTABLE     = 4'd4,
      ERR_SEL_DROP     = 4'd5,
      ERR_STRB_ON_READ = 4'd6,
      ERR_TIMEOUT      = 4'd7
   } apb_err_e;

   typedef struct packed {
      apb_err_e              code;
      logic [3:0]            slave;
      logic [MON_ADDR_W-1:0] addr;
   } apb_err_entry_t;

   // Index of the lowest set select bit, 0 when nothing is selected.
   function automatic logic [3:0] first_sel(input logic [15:0] sel);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (sel[i]) idx = 4'(i);
      return idx;
   endfunction

endpackage

// File: rtl/apb_mon_err_fifo.sv
// Synchronous error-log FIFO with sticky overflow; a push while full succeeds only
// when a pop frees the head slot in the same cycle.
module apb_mon_err_fifo #(
   parameter int WIDTH     = 40,
   parameter int LOG_DEPTH = 4
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

   logic [WIDTH-1:0] mem [LOG_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge pclk) begin
      if (preset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol monitor: classifies each bus sample, flags violations into an
// error FIFO and counts completions. Optional wait timeout with APB_MON_TIMEOUT_EN.
module apb_protocol_monitor
   import apb_mon_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SLAVE_NUM  = 8,
   parameter int TIMEOUT    = 16,
   parameter int LOG_DEPTH  = 4
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pwrite,
   input  logic                    penable,
   input  logic                    pready,
   input  logic                    pslverr,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [2:0]              pprot,
   input  logic [SLAVE_NUM-1:0]    psel,
   input  logic                    log_pop,
   output logic                    err_valid,
   output logic [3:0]              log_code,
   output logic [3:0]              log_slave,
   output logic [ADDR_WIDTH-1:0]   log_addr,
   output logic                    log_empty,
   output logic                    log_full,
   output logic                    log_overflow,
   output logic [31:0]             xfer_cnt,
   output logic [15:0]             slverr_cnt,
   output logic                    busy
);

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

   apb_state_e               state;
   logic                     cmpl_q;
   logic                     vld_p1;
   logic [ADDR_WIDTH-1:0]    cap_addr;
   logic [DATA_WIDTH-1:0]    cap_wdata;
   logic [DATA_WIDTH/8-1:0]  cap_strb;
   logic [SLAVE_NUM-1:0]     cap_sel;
   logic [2:0]               cap_prot;
   logic                     cap_write;
   logic sel_none, sel_multi, free, in_access, start, complete, err_any;
   logic e_multi, e_en_no_setup, e_en_in_setup, e_unstable, e_sel_drop, e_strb, e_timeout;
   apb_err_e                 err_code;
   apb_err_entry_t           entry_in;
   apb_err_entry_t           head;
   logic                     unused_prdata;

   assign unused_prdata = ^prdata;

   // ACCESS with cmpl_q set means the previous sample completed: the bus may idle or start anew.
   assign sel_none  = (psel == '0);
   assign sel_multi = (psel & (psel - SLAVE_NUM'(1))) != '0;
   assign free      = (state == IDLE) || (state == ACCESS && cmpl_q);
   assign in_access = (state == SETUP) || (state == ACCESS && !cmpl_q);
   assign start     = free && !sel_none && !sel_multi && !(state == IDLE && penable);
   assign complete  = in_access && !sel_none && pready;

   assign e_multi       = sel_multi;
   assign e_en_no_setup = penable && ((state == IDLE) || (free && sel_none));
   assign e_en_in_setup = penable && start && (state == ACCESS);
   assign e_unstable    = in_access && !sel_none &&
                          ((paddr != cap_addr) || (pwrite != cap_write) || (psel != cap_sel) ||
                           (pprot != cap_prot) || (pstrb != cap_strb) ||
                           (cap_write && (pwdata != cap_wdata)));
   assign e_sel_drop    = in_access && sel_none;
   assign e_strb        = start && !pwrite && (pstrb != '0);

`ifdef APB_MON_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic [7:0] wait_base;
   logic [7:0] wait_nx;

   assign wait_base = (state == SETUP) ? 8'd0 : wait_cnt;
   assign wait_nx   = (in_access && !pready && wait_base != 8'hFF) ? wait_base + 8'd1 : wait_base;
   assign e_timeout = in_access && !pready && (wait_nx == 8'(TIMEOUT)) && (wait_base != 8'(TIMEOUT));

   always_ff @(posedge pclk) begin
      if (preset) wait_cnt <= '0;
      else        wait_cnt <= wait_nx;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign e_timeout = 1'b0;
`endif

   // Lowest code wins: later assignments override earlier ones.
   always_comb begin
      err_code = ERR_NONE;
      if (e_timeout)     err_code = ERR_TIMEOUT;
      if (e_strb)        err_code = ERR_STRB_ON_READ;
      if (e_sel_drop)    err_code = ERR_SEL_DROP;
      if (e_unstable)    err_code = ERR_UNSTABLE;
      if (e_en_in_setup) err_code = ERR_EN_IN_SETUP;
      if (e_en_no_setup) err_code = ERR_EN_NO_SETUP;
      if (e_multi)       err_code = ERR_MULTI_SEL;
   end

   assign err_any = (err_code != ERR_NONE);

   always_comb begin
      entry_in.code  = err_code;
      entry_in.slave = first_sel(16'(psel));
      entry_in.addr  = MON_ADDR_W'(paddr);
   end

   // p0 -> p1: sample classification becomes state, counters and the error pulse.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state      <= IDLE;
         cmpl_q     <= 1'b0;
         vld_p1     <= 1'b0;
         xfer_cnt   <= '0;
         slverr_cnt <= '0;
      end else begin
         vld_p1 <= err_any;
         cmpl_q <= complete;
         if (start)                      state <= SETUP;
         else if (in_access && !sel_none) state <= ACCESS;
         else                            state <= IDLE;
         if (complete) xfer_cnt <= sat_inc32(xfer_cnt);
         if (complete && pslverr) slverr_cnt <= sat_inc16(slverr_cnt);
      end
   end

   // Re-capturing after an UNSTABLE report keeps one change from being logged every cycle.
   always_ff @(posedge pclk) begin
      if (start || e_unstable) begin
         cap_addr  <= paddr;
         cap_write <= pwrite;
         cap_sel   <= psel;
         cap_prot  <= pprot;
         cap_strb  <= pstrb;
         if (pwrite) cap_wdata <= pwdata;
      end
   end

   apb_mon_err_fifo #(
      .WIDTH     ($bits(apb_err_entry_t)),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_err_fifo (
      .pclk     (pclk),
      .preset   (preset),
      .push     (err_any),
      .pop      (log_pop),
      .din      (entry_in),
      .dout     (head),
      .empty    (log_empty),
      .full     (log_full),
      .overflow (log_overflow)
   );

   assign err_valid = vld_p1;
   assign log_code  = head.code;
   assign log_slave = head.slave;
   assign log_addr  = ADDR_WIDTH'(head.addr);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed bench for apb_protocol_monitor; expected values are hand-computed per vector.
module tb_apb_protocol_monitor;

   logic        pclk = 1'b0;
   logic        preset;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, penable, pready, pslverr, log_pop;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [7:0]  psel;
   logic        err_valid, log_empty, log_full, log_overflow, busy;
   logic [3:0]  log_code, log_slave;
   logic [31:0] log_addr, xfer_cnt;
   logic [15:0] slverr_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int ev_cnt = 0;

   always #5 pclk = ~pclk;

   apb_protocol_monitor #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .SLAVE_NUM  (8),
      .TIMEOUT    (4),
      .LOG_DEPTH  (4)
   ) dut (
      .pclk         (pclk),
      .preset       (preset),
      .paddr        (paddr),
      .pwdata       (pwdata),
      .prdata       (prdata),
      .pwrite       (pwrite),
      .penable      (penable),
      .pready       (pready),
      .pslverr      (pslverr),
      .pstrb        (pstrb),
      .pprot        (pprot),
      .psel         (psel),
      .log_pop      (log_pop),
      .err_valid    (err_valid),
      .log_code     (log_code),
      .log_slave    (log_slave),
      .log_addr     (log_addr),
      .log_empty    (log_empty),
      .log_full     (log_full),
      .log_overflow (log_overflow),
      .xfer_cnt     (xfer_cnt),
      .slverr_cnt   (slverr_cnt),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
      if (err_valid) ev_cnt++;
   endtask

   task automatic bus_idle(input int n);
      psel = '0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0; pwrite = 1'b0; pstrb = '0;
      repeat (n) tick();
   endtask

   task automatic pop();
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
   endtask

   task automatic xfer(input int idx, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input int waits,
                       input logic err);
      psel = 8'(1 << idx); pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      penable = 1'b0; pready = 1'b0;
      tick();
      penable = 1'b1;
      repeat (waits) tick();
      pready = 1'b1; pslverr = err;
      tick();
      penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
   endtask

   initial begin
      preset = 1'b1; paddr = '0; pwdata = '0; prdata = 32'h1234_5678; pprot = 3'b010;
      log_pop = 1'b0;
      bus_idle(2);
      chk("rst_err_valid", 64'(err_valid), 64'(0));
      chk("rst_log_code", 64'(log_code), 64'(0));
      chk("rst_log_slave", 64'(log_slave), 64'(0));
      chk("rst_log_addr", 64'(log_addr), 64'(0));
      chk("rst_log_empty", 64'(log_empty), 64'(1));
      chk("rst_log_full", 64'(log_full), 64'(0));
      chk("rst_overflow", 64'(log_overflow), 64'(0));
      chk("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
      chk("rst_slverr_cnt", 64'(slverr_cnt), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      preset = 1'b0;
      bus_idle(1);

      // legal write (0 waits) then back-to-back read (3 waits)
      ev_cnt = 0;
      xfer(2, 1'b1, 32'h100, 32'hCAFE_0001, 4'hF, 0, 1'b0);
      xfer(2, 1'b0, 32'h104, 32'h0, 4'h0, 3, 1'b0);
      bus_idle(2);
      chk("legal_err_cnt", 64'(ev_cnt), 64'(0));
      chk("legal_xfer_cnt", 64'(xfer_cnt), 64'(2));
      chk("legal_busy", 64'(busy), 64'(0));
      chk("legal_empty", 64'(log_empty), 64'(1));
      preset = 1'b1; bus_idle(1); preset = 1'b0;
      chk("legal_rst_xfer", 64'(xfer_cnt), 64'(0));

      // two selects in setup
      psel = 8'h06; penable = 1'b0; paddr = 32'h40; tick();
      chk("multi_valid", 64'(err_valid), 64'(1));
      chk("multi_code", 64'(log_code), 64'(1));
      chk("multi_slave", 64'(log_slave), 64'(1));
      chk("multi_addr", 64'(log_addr), 64'(32'h40));
      bus_idle(1);
      chk("multi_pulse_end", 64'(err_valid), 64'(0));
      chk("multi_one_entry_kept", 64'(log_empty), 64'(0));
      pop();
      chk("multi_popped", 64'(log_empty), 64'(1));

      // address change during an ACCESS wait
      ev_cnt = 0;
      psel = 8'h08; pwrite = 1'b0; pstrb = 4'h0; paddr = 32'h10; penable = 1'b0; tick();
      penable = 1'b1; pready = 1'b0; tick();
      chk("unst_busy", 64'(busy), 64'(1));
      chk("unst_quiet", 64'(err_valid), 64'(0));
      paddr = 32'h14; tick();
      chk("unst_valid", 64'(err_valid), 64'(1));
      chk("unst_code", 64'(log_code), 64'(4));
      chk("unst_slave", 64'(log_slave), 64'(3));
      chk("unst_addr", 64'(log_addr), 64'(32'h14));
      tick();
      chk("unst_once", 64'(err_valid), 64'(0));
      pready = 1'b1; tick();
      bus_idle(1);
      chk("unst_err_cnt", 64'(ev_cnt), 64'(1));
      chk("unst_xfer_cnt", 64'(xfer_cnt), 64'(1));
      pop();

      // 10 wait cycles with TIMEOUT=4
      ev_cnt = 0;
      psel = 8'h02; pwrite = 1'b0; pstrb = 4'h0; paddr = 32'h20; penable = 1'b0; tick();
      penable = 1'b1; pready = 1'b0;
      repeat (10) tick();
      chk("tmo_xfer_before", 64'(xfer_cnt), 64'(1));
      pready = 1'b1; tick();
      bus_idle(1);
      chk("tmo_xfer_after", 64'(xfer_cnt), 64'(2));
`ifdef APB_MON_TIMEOUT_EN
      chk("tmo_err_cnt", 64'(ev_cnt), 64'(1));
      chk("tmo_code", 64'(log_code), 64'(7));
      chk("tmo_slave", 64'(log_slave), 64'(1));
      chk("tmo_addr", 64'(log_addr), 64'(32'h20));
      pop();
`else
      chk("tmo_err_cnt", 64'(ev_cnt), 64'(0));
`endif
      chk("tmo_empty", 64'(log_empty), 64'(1));

      // five EN_NO_SETUP errors into a 4-deep log
      ev_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         psel = '0; penable = 1'b1; paddr = 32'hA0 + i; tick();
      end
      penable = 1'b0; tick();
      chk("ovf_err_cnt", 64'(ev_cnt), 64'(5));
      chk("ovf_full", 64'(log_full), 64'(1));
      chk("ovf_flag", 64'(log_overflow), 64'(1));
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_code", 64'(log_code), 64'(2));
         chk("ovf_drain_addr", 64'(log_addr), 64'(32'hA0 + i));
         pop();
      end
      chk("ovf_drained", 64'(log_empty), 64'(1));
      for (int i = 0; i < 4; i++) begin
         penable = 1'b1; paddr = 32'hB0 + i; tick();
      end
      penable = 1'b1; paddr = 32'hB4; log_pop = 1'b1; tick();
      log_pop = 1'b0; penable = 1'b0; tick();
      chk("pp_full", 64'(log_full), 64'(1));
      chk("pp_sticky_ovf", 64'(log_overflow), 64'(1));
      for (int i = 0; i < 4; i++) begin
         chk("pp_drain_addr", 64'(log_addr), 64'(32'hB1 + i));
         pop();
      end
      chk("pp_drained", 64'(log_empty), 64'(1));

      // slave error on a strobe-less write, then a read with strobes
      xfer(5, 1'b1, 32'h50, 32'h1234, 4'h0, 1, 1'b1);
      bus_idle(1);
      chk("slverr_cnt", 64'(slverr_cnt), 64'(1));
      chk("slverr_xfer", 64'(xfer_cnt), 64'(3));
      ev_cnt = 0;
      psel = 8'h20; pwrite = 1'b0; pstrb = 4'h3; paddr = 32'h54; penable = 1'b0; tick();
      chk("strb_valid", 64'(err_valid), 64'(1));
      chk("strb_code", 64'(log_code), 64'(6));
      chk("strb_slave", 64'(log_slave), 64'(5));
      chk("strb_addr", 64'(log_addr), 64'(32'h54));
      penable = 1'b1; pready = 1'b1; tick();
      bus_idle(1);
      chk("strb_xfer", 64'(xfer_cnt), 64'(4));
      chk("strb_err_cnt", 64'(ev_cnt), 64'(1));
      pop();

      // penable held high into a back-to-back setup
      ev_cnt = 0;
      xfer(1, 1'b1, 32'h60, 32'h55, 4'hF, 0, 1'b0);
      psel = 8'h02; penable = 1'b1; pwrite = 1'b1; pstrb = 4'hF; paddr = 32'h64; tick();
      chk("ens_code", 64'(log_code), 64'(3));
      chk("ens_slave", 64'(log_slave), 64'(1));
      pready = 1'b1; tick();
      bus_idle(1);
      chk("ens_xfer", 64'(xfer_cnt), 64'(6));
      chk("ens_err_cnt", 64'(ev_cnt), 64'(1));
      pop();

      // select dropped before pready
      psel = 8'h04; pwrite = 1'b0; pstrb = 4'h0; paddr = 32'h30; penable = 1'b0; tick();
      penable = 1'b1; pready = 1'b0; tick();
      psel = '0; penable = 1'b0; tick();
      chk("drop_valid", 64'(err_valid), 64'(1));
      chk("drop_code", 64'(log_code), 64'(5));
      chk("drop_slave", 64'(log_slave), 64'(0));
      chk("drop_addr", 64'(log_addr), 64'(32'h30));
      tick();
      chk("drop_quiet", 64'(err_valid), 64'(0));
      chk("drop_idle", 64'(busy), 64'(0));
      pop();

      // reset in the middle of a transfer, penable still high afterwards
      psel = 8'h04; pwrite = 1'b1; pstrb = 4'hF; paddr = 32'h70; penable = 1'b0; tick();
      penable = 1'b1; pready = 1'b0; tick();
      preset = 1'b1; tick(); preset = 1'b0;
      chk("mid_rst_xfer", 64'(xfer_cnt), 64'(0));
      chk("mid_rst_slverr", 64'(slverr_cnt), 64'(0));
      chk("mid_rst_ovf", 64'(log_overflow), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      tick();
      chk("mid_rst_valid", 64'(err_valid), 64'(1));
      chk("mid_rst_code", 64'(log_code), 64'(2));
      chk("mid_rst_slave", 64'(log_slave), 64'(2));
      chk("mid_rst_addr", 64'(log_addr), 64'(32'h70));
      bus_idle(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
